// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage in front of decode.
//   Holds the PC and reads a synchronous instruction memory that returns data
//   one cycle after the request. Owns the IF/ID register (o_inst/o_pc/o_valid).
//   Handles decode stall, jump redirect/flush and HALT. A 1-entry skid buffer
//   catches the word that returns while decode is stalled, so no word is lost
//   or duplicated.
// Ports:
//   clk, reset      clock, async active-high reset
//   i_stall         decode not accepting; IF/ID holds
//   i_jump          redirect + flush, highest priority
//   i_jump_target   redirect PC
//   o_imem_en       imem read request this cycle
//   o_imem_addr     imem read address (current PC)
//   i_imem_rdata    imem data, valid the cycle after o_imem_en
//   o_inst, o_pc    IF/ID instruction and its PC
//   o_valid         IF/ID holds a real instruction (0 = bubble)
//   o_halted        stage is in HALTED
module fetch_stage #(
    parameter int               ADDR_W      = 8,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter logic [3:0]       HALT_OPCODE = 4'hF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_stall,
    input  logic              i_jump,
    input  logic [ADDR_W-1:0] i_jump_target,
    output logic              o_imem_en,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic [15:0]       i_imem_rdata,
    output logic [15:0]       o_inst,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_valid,
    output logic              o_halted
);

    typedef enum logic {FETCH, HALTED} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              skid_valid_q, skid_valid_d;
    logic [15:0]       skid_inst_q, skid_inst_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
    logic [15:0]       inst_q, inst_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;
    logic              valid_q, valid_d;

    logic              issue;
    logic              load;
    logic [15:0]       ld_inst;
    logic [ADDR_W-1:0] ld_pc;

    // No new read while the skid is occupied: that guarantees a return and a
    // skid drain never collide in the same cycle.
    assign issue = (state_q == FETCH) & ~i_jump & ~i_stall & ~skid_valid_q;

    assign o_imem_en   = issue & ~reset;
    assign o_imem_addr = pc_q;
    assign o_inst      = inst_q;
    assign o_pc        = out_pc_q;
    assign o_valid     = valid_q;
    assign o_halted    = (state_q == HALTED);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        skid_valid_d  = skid_valid_q;
        skid_inst_d   = skid_inst_q;
        skid_pc_d     = skid_pc_q;
        inst_d        = inst_q;
        out_pc_d      = out_pc_q;
        valid_d       = valid_q;
        load          = 1'b0;
        ld_inst       = i_imem_rdata;
        ld_pc         = inflight_pc_q;

        if (i_jump) begin
            // Flush everything in flight; target is issued next cycle.
            pc_d         = i_jump_target;
            inflight_d   = 1'b0;
            skid_valid_d = 1'b0;
            valid_d      = 1'b0;
            state_d      = FETCH;
        end else begin
            if (issue) begin
                pc_d          = pc_q + 1'b1;
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
            end else begin
                inflight_d = 1'b0;
            end

            if (i_stall) begin
                // Skid is always empty here: a return only follows an
                // unstalled issue cycle, which required an empty skid.
                if (inflight_q) begin
                    skid_valid_d = 1'b1;
                    skid_inst_d  = i_imem_rdata;
                    skid_pc_d    = inflight_pc_q;
                end
            end else begin
                if (skid_valid_q) begin
                    load         = 1'b1;
                    ld_inst      = skid_inst_q;
                    ld_pc        = skid_pc_q;
                    skid_valid_d = 1'b0;
                end else if (inflight_q) begin
                    load = 1'b1;
                end

                if (load) begin
                    inst_d   = ld_inst;
                    out_pc_d = ld_pc;
                    valid_d  = 1'b1;
                    // HALT: drop the read issued this cycle, park PC after it.
                    if (ld_inst[15:12] == HALT_OPCODE) begin
                        state_d    = HALTED;
                        inflight_d = 1'b0;
                        pc_d       = ld_pc + 1'b1;
                    end
                end else begin
                    valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            skid_valid_q  <= 1'b0;
            skid_inst_q   <= '0;
            skid_pc_q     <= '0;
            inst_q        <= '0;
            out_pc_q      <= '0;
            valid_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            skid_valid_q  <= skid_valid_d;
            skid_inst_q   <= skid_inst_d;
            skid_pc_q     <= skid_pc_d;
            inst_q        <= inst_d;
            out_pc_q      <= out_pc_d;
            valid_q       <= valid_d;
        end
    end

endmodule
